// File: rtl/universal_shreg.sv
// universal_shreg: WIDTH-bit universal shift register with parallel load,
// shift/rotate in both directions, synchronous clear/preset, an asynchronous
// reset, and a multi-step shift sequencer reporting busy/done.
module universal_shreg #(
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]  PRESET_VAL = {WIDTH{1'b1}},
  parameter int                AW         = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             preset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  input  logic             start,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;

  // Largest meaningful step count: a full revolution of the register.
  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [2:0]       seq_mode, seq_mode_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;

  // Modes that move bits; only these launch a sequence.
  function automatic logic is_shift(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ROR);
  endfunction

  // One single-cycle operation of the register for a given mode.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_LOAD:  r = ld;
      M_SHL:   r = {cur[WIDTH-2:0], sl};
      M_SHR:   r = {sr, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Requests beyond one full revolution are clamped to WIDTH steps.
  function automatic logic [AW-1:0] sat_amount(input logic [AW-1:0] a);
    return (a > AMT_MAX) ? AMT_MAX : a;
  endfunction

  // Next-state and next-q selection in priority order: clear, preset,
  // running sequence, sequence launch, single-cycle mode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    seq_mode_nxt = seq_mode;
    q_nxt        = q;
    done_nxt     = 1'b0;
    if (clear) begin
      q_nxt     = '0;
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (preset) begin
      q_nxt     = PRESET_VAL;
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (state == S_RUN) begin
      if (cnt != '0) begin
        // Serial inputs are sampled live on every step.
        q_nxt   = apply_op(seq_mode, q, d, sl_in, sr_in);
        cnt_nxt = cnt - AW'(1);
      end else begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
    end else if (start && is_shift(mode)) begin
      // Launch edge: capture the operation, leave q untouched.
      seq_mode_nxt = mode;
      cnt_nxt      = sat_amount(amount);
      state_nxt    = S_RUN;
    end else begin
      q_nxt = apply_op(mode, q, d, sl_in, sr_in);
    end
  end

  // FSM, step counter and captured mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      seq_mode <= M_HOLD;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      seq_mode <= seq_mode_nxt;
      done     <= done_nxt;
    end
  end

  // Register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign busy = (state == S_RUN);
  assign qbar = ~q;

endmodule

// File: doc/universal_shreg.md
# universal_shreg

Parametrised universal shift register with per-register inverted outputs. It generalises the single-bit preset/clear flip-flop to WIDTH bits and adds parallel load, left and right shift, rotate, and a multi-step shift sequencer with a busy/done handshake. It sits in datapath staging, serial-to-parallel conversion, and bit-alignment paths that need a forced-known state without resetting the whole design.

## Interface
- WIDTH, 8: register width in bits, minimum 2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded by asynchronous reset.
- PRESET_VAL, {WIDTH{1'b1}}: value loaded by synchronous preset.
- AW, $clog2(WIDTH+1): width of amount (derived; do not override).

Ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge except reset.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; forces q to 0.
- preset  in  1  synchronous preset; forces q to PRESET_VAL.
- mode  in  3  operation select (see Operation).
- d  in  WIDTH  parallel load data.
- sl_in  in  1  serial input that enters bit 0 on a left shift.
- sr_in  in  1  serial input that enters bit WIDTH-1 on a right shift.
- start  in  1  launches a multi-step shift of amount steps using mode.
- amount  in  AW  number of steps; values above WIDTH saturate to WIDTH.
- q  out  WIDTH  register contents.
- qbar  out  WIDTH  combinational ~q at all times, including during reset.
- busy  out  1  multi-step sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.

## Operation
- Mode encoding:
  - 000: hold.
  - 001: load d.
  - 010: shift left, q <= {q[W-2:0], sl_in}.
  - 011: shift right, q <= {sr_in, q[W-1:1]}.
  - 100: rotate left.
  - 101: rotate right.
  - 110 and 111: hold.
- Priority, highest first:
  1. rst_n low.
  2. clear.
  3. preset.
  4. Active sequence step.
  5. start with a shift mode while idle.
  6. Single-cycle mode operation.
- clear and preset both high: clear wins, q = 0.
- Idle, start=0: the mode operation applies every edge.
- Idle, start=1, mode in 010..101:
  - Latch mode and the saturated amount into internal registers.
  - q is not changed on the launch edge.
  - busy rises.
- Idle, start=1, mode in 000, 001, 110 or 111: start is ignored; the mode operation applies as if start were 0.
- Sequence FSM:
  - States: IDLE -> RUN -> IDLE.
  - Remaining-step counter is AW bits wide.
  - In RUN, each edge:
    - If the counter is nonzero: perform one step of the latched mode, sampling sl_in and sr_in live that cycle, and decrement the counter.
    - If the counter is zero: return to IDLE and pulse done for one cycle.
- Inputs ignored while busy: mode, d and start.
- clear or preset while busy:
  - Applies its value to q.
  - Aborts the sequence: the FSM goes to IDLE and done does not pulse.
- amount=0 with a shift mode:
  - busy is high for one cycle.
  - done pulses.
  - q is unchanged.

## Timing
- Reset values: q = RESET_VAL, qbar = ~RESET_VAL, busy = 0, done = 0, FSM = IDLE, counter = 0.
- Reset is asynchronous on assertion; release is synchronous to the next clk edge.
- Single-cycle ops: q updates at the edge where mode is sampled (1-cycle latency).
- Multi-step sequence, with the launch at edge E0 and amount N:
  - busy is high from after E0 until after E(N+1).
  - Steps occur at E1..EN.
  - At E(N+1) the FSM returns to IDLE and done goes high for the cycle after E(N+1).
  - q holds its final value from after EN.
  - For N=0, busy is high for 1 cycle and done rises after E1.
- A new start is accepted on the same edge where done is high, since busy is 0 then; back-to-back sequences have no gap cycle.
- qbar has zero latency relative to q.

## Test plan
- Reset then load (WIDTH=8): assert rst_n=0 mid-cycle -> q=8'h00 and qbar=8'hFF immediately. Release, then mode=001 with d=8'hA5 -> q=8'hA5 and qbar=8'h5A after 1 edge.
- Single shifts and rotates from q=8'h81:
  - Shift left with sl_in=0 -> q=8'h02.
  - Shift right with sr_in=1 -> q=8'hC0.
  - Rotate left -> q=8'h03.
  - Rotate right -> q=8'hC0.
  - mode=110 -> q unchanged.
- Multi-step sequence: q=8'h01, mode=100 (rotate left), amount=3, start=1 for one cycle -> busy high for 4 cycles, q=8'h08 after the 4th edge, done high for exactly 1 cycle. mode changes during busy have no effect.
- Saturation and zero:
  - amount=15, rotate left, q=8'h01 -> 8 steps, busy high for 9 cycles, q=8'h01.
  - amount=0 -> busy high for 1 cycle, done pulses, q unchanged.
- Abort and priority:
  - clear pulsed at the 2nd step of a 5-step shift -> q=8'h00, busy=0 next cycle, done never asserted.
  - clear=1 and preset=1 together -> q=8'h00.
  - preset alone -> q=8'hFF.
- Async reset mid-sequence: rst_n=0 while busy -> q=RESET_VAL, busy=0 and done=0 immediately. After release, start is accepted normally.
